serv_dbus_if: RTL and testbench



---
 rtl/serv_dbus_pkg.sv | 21 ++
 rtl/serv_dbus_if_lane.sv | 59 +++++
 rtl/serv_dbus_if.sv | 138 +++++++++++++
 tb/tb_serv_dbus_if.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/serv_dbus_pkg.sv
// Shared types and helpers for the SERV bit-serial data-bus interface.
// Size encodings follow funct3[1:0]; the unused code 2'b11 behaves as a word.
package serv_dbus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT_IN,
        ST_BUS,
        ST_SHIFT_OUT
    } state_t;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;

    // size[1] set covers both SZ_W and the reserved 2'b11 encoding
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lsb);
        return ((size == SZ_H) && lsb[0]) || (size[1] && (lsb != 2'b00));
    endfunction

endpackage

// File: rtl/serv_dbus_if_lane.sv
// Byte-lane logic: Wishbone byte enables, store-data replication and the
// per-cycle bit select with sign/zero extension for the serial load result.
module serv_dbus_lane
    import serv_dbus_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  lsb,
    input  logic [31:0] data,
    input  logic [4:0]  cnt,
    output logic [3:0]  sel,
    output logic [31:0] dat,
    output logic        rd
);

    logic [1:0] size;
    logic [4:0] base;
    logic [4:0] last_idx;
    logic [5:0] width;
    logic [4:0] pos;
    logic [4:0] sign_pos;
    logic       in_range;

    assign size = funct3[1] ? SZ_W : funct3[1:0];
    assign base = {lsb, 3'b000};

    always_comb begin
        sel      = 4'b1111;
        dat      = data;
        width    = 6'd32;
        last_idx = 5'd31;
        case (size)
            SZ_B: begin
                sel      = 4'b0001 << lsb;
                dat      = {4{data[7:0]}};
                width    = 6'd8;
                last_idx = 5'd7;
            end
            SZ_H: begin
                sel      = lsb[1] ? 4'b1100 : 4'b0011;
                dat      = {2{data[15:0]}};
                width    = 6'd16;
                last_idx = 5'd15;
            end
            default: begin
                sel      = 4'b1111;
                dat      = data;
                width    = 6'd32;
                last_idx = 5'd31;
            end
        endcase
    end

    // Aligned accesses keep base+offset inside the word, so 5-bit wrap is harmless
    assign pos      = base + cnt;
    assign sign_pos = base + last_idx;
    assign in_range = ({1'b0, cnt} < width);
    assign rd       = in_range ? data[pos] : (~funct3[2] & data[sign_pos]);

endmodule

// File: rtl/serv_dbus_if.sv
// SERV data-bus interface: serialises store data into a Wishbone write, or
// performs a Wishbone read and streams the extended load result LSB first.
module serv_dbus_if
    import serv_dbus_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_start,
    input  logic        i_we,
    input  logic [2:0]  i_funct3,
    input  logic [1:0]  i_lsb,
    input  logic [31:0] i_adr,
    input  logic        i_rs2,
    output logic [31:0] o_dbus_adr,
    output logic        o_dbus_cyc,
    output logic        o_dbus_we,
    output logic [3:0]  o_dbus_sel,
    output logic [31:0] o_dbus_dat,
    input  logic        i_dbus_ack,
    input  logic [31:0] i_dbus_rdt,
    output logic        o_rd,
    output logic        o_rd_valid,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_misalign
);

    state_t      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [31:0] data_q, data_d;
    logic        we_q, we_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [1:0]  lsb_q, lsb_d;
    logic [31:0] adr_q, adr_d;
    logic        done_q, done_d;
    logic        misalign_q, misalign_d;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= 5'd0;
            done_q     <= 1'b0;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            done_q     <= done_d;
            misalign_q <= misalign_d;
        end
    end

    // Datapath registers carry no reset; outputs derived from them are qualified by state
    always_ff @(posedge i_clk) begin
        data_q   <= data_d;
        we_q     <= we_d;
        funct3_q <= funct3_d;
        lsb_q    <= lsb_d;
        adr_q    <= adr_d;
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        data_d     = data_q;
        we_d       = we_q;
        funct3_d   = funct3_q;
        lsb_d      = lsb_q;
        adr_d      = adr_q;
        done_d     = 1'b0;
        misalign_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                cnt_d = 5'd0;
                if (i_start) begin
                    we_d     = i_we;
                    funct3_d = i_funct3;
                    lsb_d    = i_lsb;
                    adr_d    = i_adr;
                    if (is_misaligned(i_funct3[1:0], i_lsb)) begin
                        done_d     = 1'b1;
                        misalign_d = 1'b1;
                    end else if (i_we) begin
                        state_d = ST_SHIFT_IN;
                    end else begin
                        state_d = ST_BUS;
                    end
                end
            end
            ST_SHIFT_IN: begin
                data_d = {i_rs2, data_q[31:1]};
                cnt_d  = cnt_q + 5'd1;
                if (cnt_q == 5'd31) begin
                    state_d = ST_BUS;
                end
            end
            ST_BUS: begin
                if (i_dbus_ack) begin
                    if (we_q) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        data_d  = i_dbus_rdt;
                        state_d = ST_SHIFT_OUT;
                    end
                end
            end
            ST_SHIFT_OUT: begin
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'd31) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    serv_dbus_lane u_lane (
        .funct3 (funct3_q),
        .lsb    (lsb_q),
        .data   (data_q),
        .cnt    (cnt_q),
        .sel    (o_dbus_sel),
        .dat    (o_dbus_dat),
        .rd     (o_rd)
    );

    assign o_dbus_adr = adr_q;
    assign o_dbus_cyc = (state_q == ST_BUS);
    assign o_dbus_we  = we_q & o_dbus_cyc;
    assign o_rd_valid = (state_q == ST_SHIFT_OUT);
    assign o_busy     = (state_q != ST_IDLE);
    assign o_done     = done_q;
    assign o_misalign = misalign_q;

endmodule

// File: tb/tb_serv_dbus_if.sv
// Self-checking bench for serv_dbus_if: table of memory ops with expected
// bus/result values queued as a scoreboard, plus chained-start and reset sequences.
module tb_serv_dbus_if;

    typedef struct packed {
        logic        we;
        logic [2:0]  funct3;
        logic [1:0]  lsb;
        logic [31:0] adr;
        logic [31:0] wdat;
        logic [31:0] rdt;
        logic [7:0]  waits;
        logic        mis;
        logic [3:0]  exp_sel;
        logic [31:0] exp_val;
    } vec_t;

    logic        clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        i_start = 1'b0;
    logic        i_we = 1'b0;
    logic [2:0]  i_funct3 = 3'b000;
    logic [1:0]  i_lsb = 2'b00;
    logic [31:0] i_adr = 32'h0;
    logic        i_rs2 = 1'b0;
    logic        i_dbus_ack = 1'b0;
    logic [31:0] i_dbus_rdt = 32'h0;
    logic [31:0] o_dbus_adr;
    logic        o_dbus_cyc;
    logic        o_dbus_we;
    logic [3:0]  o_dbus_sel;
    logic [31:0] o_dbus_dat;
    logic        o_rd;
    logic        o_rd_valid;
    logic        o_busy;
    logic        o_done;
    logic        o_misalign;

    int   checks = 0;
    int   errors = 0;
    vec_t vecs[13];
    vec_t exp_q[$];

    serv_dbus_if dut (
        .i_clk      (clk),
        .i_rst      (i_rst),
        .i_start    (i_start),
        .i_we       (i_we),
        .i_funct3   (i_funct3),
        .i_lsb      (i_lsb),
        .i_adr      (i_adr),
        .i_rs2      (i_rs2),
        .o_dbus_adr (o_dbus_adr),
        .o_dbus_cyc (o_dbus_cyc),
        .o_dbus_we  (o_dbus_we),
        .o_dbus_sel (o_dbus_sel),
        .o_dbus_dat (o_dbus_dat),
        .i_dbus_ack (i_dbus_ack),
        .i_dbus_rdt (i_dbus_rdt),
        .o_rd       (o_rd),
        .o_rd_valid (o_rd_valid),
        .o_busy     (o_busy),
        .o_done     (o_done),
        .o_misalign (o_misalign)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic we, input logic [2:0] f3, input logic [1:0] lsb,
                                input logic [31:0] adr, input logic [31:0] wdat,
                                input logic [31:0] rdt, input logic [7:0] waits,
                                input logic mis, input logic [3:0] sel, input logic [31:0] val);
        vec_t v;
        v.we = we;  v.funct3 = f3;  v.lsb = lsb;  v.adr = adr;  v.wdat = wdat;
        v.rdt = rdt;  v.waits = waits;  v.mis = mis;  v.exp_sel = sel;  v.exp_val = val;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives i_start in the current cycle and returns in the o_done cycle
    task automatic applyStimulus(input vec_t v);
        vec_t        e;
        logic [31:0] res;
        logic [31:0] cyc_seen;
        logic [31:0] valid_cnt;
        logic [31:0] done_seen;
        i_start  = 1'b1;
        i_we     = v.we;
        i_funct3 = v.funct3;
        i_lsb    = v.lsb;
        i_adr    = v.adr;
        exp_q.push_back(v);
        tick();
        i_start  = 1'b0;
        i_we     = ~v.we;
        i_funct3 = ~v.funct3;
        i_lsb    = ~v.lsb;
        i_adr    = 32'hFFFF_FFFF;
        if (v.mis) begin
            e = exp_q.pop_front();
            checkOutput("mis_done", 32'(o_done), 32'd1);
            checkOutput("mis_pulse", 32'(o_misalign), 32'(e.mis));
            checkOutput("mis_busy", 32'(o_busy), 32'd0);
            checkOutput("mis_cyc", 32'(o_dbus_cyc), 32'd0);
        end else if (v.we) begin
            checkOutput("st_busy", 32'(o_busy), 32'd1);
            checkOutput("st_done_clr", 32'(o_done), 32'd0);
            cyc_seen = 32'd0;
            for (int i = 0; i < 32; i++) begin
                i_rs2 = v.wdat[i];
                if (o_dbus_cyc) cyc_seen++;
                tick();
            end
            i_rs2 = 1'b0;
            checkOutput("st_cyc_during_shift", cyc_seen, 32'd0);
            e = exp_q.pop_front();
            checkOutput("st_cyc", 32'(o_dbus_cyc), 32'd1);
            checkOutput("st_we", 32'(o_dbus_we), 32'd1);
            checkOutput("st_adr", o_dbus_adr, e.adr);
            checkOutput("st_sel", 32'(o_dbus_sel), 32'(e.exp_sel));
            checkOutput("st_dat", o_dbus_dat, e.exp_val);
            repeat (int'(v.waits)) tick();
            checkOutput("st_cyc_held", 32'(o_dbus_cyc), 32'd1);
            i_dbus_ack = 1'b1;
            tick();
            i_dbus_ack = 1'b0;
            checkOutput("st_done", 32'(o_done), 32'd1);
            checkOutput("st_cyc_drop", 32'(o_dbus_cyc), 32'd0);
            checkOutput("st_misalign", 32'(o_misalign), 32'd0);
        end else begin
            checkOutput("ld_busy", 32'(o_busy), 32'd1);
            checkOutput("ld_done_clr", 32'(o_done), 32'd0);
            e = exp_q.pop_front();
            checkOutput("ld_cyc", 32'(o_dbus_cyc), 32'd1);
            checkOutput("ld_we", 32'(o_dbus_we), 32'd0);
            checkOutput("ld_adr", o_dbus_adr, e.adr);
            checkOutput("ld_sel", 32'(o_dbus_sel), 32'(e.exp_sel));
            repeat (int'(v.waits)) tick();
            checkOutput("ld_cyc_held", 32'(o_dbus_cyc), 32'd1);
            i_dbus_ack = 1'b1;
            i_dbus_rdt = v.rdt;
            tick();
            i_dbus_ack = 1'b0;
            i_dbus_rdt = ~v.rdt;
            valid_cnt = 32'd0;
            done_seen = 32'd0;
            res = 32'd0;
            for (int i = 0; i < 32; i++) begin
                if (o_rd_valid) valid_cnt++;
                if (o_done) done_seen++;
                res[i] = o_rd;
                tick();
            end
            checkOutput("ld_valid_cycles", valid_cnt, 32'd32);
            checkOutput("ld_early_done", done_seen, 32'd0);
            checkOutput("ld_result", res, e.exp_val);
            checkOutput("ld_done", 32'(o_done), 32'd1);
            checkOutput("ld_valid_drop", 32'(o_rd_valid), 32'd0);
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vecs[0]  = mk(1'b1, 3'b010, 2'd0, 32'h1000_0004, 32'hDEAD_BEEF, 32'h0, 8'd3, 1'b0, 4'b1111, 32'hDEAD_BEEF);
        vecs[1]  = mk(1'b1, 3'b000, 2'd2, 32'h2000_0010, 32'h0000_00A5, 32'h0, 8'd0, 1'b0, 4'b0100, 32'hA5A5_A5A5);
        vecs[2]  = mk(1'b0, 3'b000, 2'd3, 32'h3000_0000, 32'h0, 32'h80FF_FF00, 8'd2, 1'b0, 4'b1000, 32'hFFFF_FF80);
        vecs[3]  = mk(1'b0, 3'b100, 2'd3, 32'h3000_0000, 32'h0, 32'h80FF_FF00, 8'd0, 1'b0, 4'b1000, 32'h0000_0080);
        vecs[4]  = mk(1'b0, 3'b001, 2'd0, 32'h3000_0008, 32'h0, 32'h7FFF_8123, 8'd1, 1'b0, 4'b0011, 32'hFFFF_8123);
        vecs[5]  = mk(1'b0, 3'b010, 2'd0, 32'h4000_0000, 32'h0, 32'h1234_5678, 8'd4, 1'b0, 4'b1111, 32'h1234_5678);
        vecs[6]  = mk(1'b1, 3'b001, 2'd2, 32'h5000_0000, 32'hCAFE_BEEF, 32'h0, 8'd1, 1'b0, 4'b1100, 32'hBEEF_BEEF);
        vecs[7]  = mk(1'b0, 3'b000, 2'd1, 32'h6000_0000, 32'h0, 32'h0000_7F00, 8'd0, 1'b0, 4'b0010, 32'h0000_007F);
        vecs[8]  = mk(1'b0, 3'b011, 2'd0, 32'h7000_0000, 32'h0, 32'hA5A5_0F0F, 8'd0, 1'b0, 4'b1111, 32'hA5A5_0F0F);
        vecs[9]  = mk(1'b0, 3'b001, 2'd1, 32'h8000_0000, 32'h0, 32'h0, 8'd0, 1'b1, 4'b0000, 32'h0);
        vecs[10] = mk(1'b1, 3'b010, 2'd2, 32'h8000_0004, 32'h1111_1111, 32'h0, 8'd0, 1'b1, 4'b0000, 32'h0);
        vecs[11] = mk(1'b0, 3'b101, 2'd3, 32'h8000_0008, 32'h0, 32'h0, 8'd0, 1'b1, 4'b0000, 32'h0);
        vecs[12] = mk(1'b1, 3'b000, 2'd1, 32'h9000_0000, 32'h1234_5637, 32'h0, 8'd2, 1'b0, 4'b0010, 32'h3737_3737);

        repeat (3) tick();
        checkOutput("rst_cyc", 32'(o_dbus_cyc), 32'd0);
        checkOutput("rst_busy", 32'(o_busy), 32'd0);
        checkOutput("rst_done", 32'(o_done), 32'd0);
        i_rst = 1'b0;
        tick();
        checkOutput("idle_we", 32'(o_dbus_we), 32'd0);
        checkOutput("idle_misalign", 32'(o_misalign), 32'd0);
        checkOutput("idle_rd_valid", 32'(o_rd_valid), 32'd0);

        for (int k = 0; k < 13; k++) begin
            applyStimulus(vecs[k]);
            tick();
            checkOutput("post_done_clr", 32'(o_done), 32'd0);
            checkOutput("post_misalign_clr", 32'(o_misalign), 32'd0);
            checkOutput("post_idle_cyc", 32'(o_dbus_cyc), 32'd0);
        end

        // lhu ending in o_done, with a new load started in that same cycle
        applyStimulus(mk(1'b0, 3'b101, 2'd2, 32'hA000_0000, 32'h0, 32'h8001_1234, 8'd1, 1'b0, 4'b1100, 32'h0000_8001));
        applyStimulus(mk(1'b0, 3'b010, 2'd0, 32'hA000_0004, 32'h0, 32'h0BAD_F00D, 8'd0, 1'b0, 4'b1111, 32'h0BAD_F00D));
        tick();

        // Reset while waiting for ack, then a stray ack must be ignored
        i_start  = 1'b1;
        i_we     = 1'b0;
        i_funct3 = 3'b010;
        i_lsb    = 2'd0;
        i_adr    = 32'hB000_0000;
        tick();
        i_start = 1'b0;
        checkOutput("rstbus_cyc_before", 32'(o_dbus_cyc), 32'd1);
        tick();
        i_rst = 1'b1;
        tick();
        i_rst = 1'b0;
        checkOutput("rstbus_cyc", 32'(o_dbus_cyc), 32'd0);
        checkOutput("rstbus_busy", 32'(o_busy), 32'd0);
        checkOutput("rstbus_done", 32'(o_done), 32'd0);
        i_dbus_ack = 1'b1;
        i_dbus_rdt = 32'h5555_5555;
        tick();
        i_dbus_ack = 1'b0;
        checkOutput("stray_ack_done", 32'(o_done), 32'd0);
        checkOutput("stray_ack_busy", 32'(o_busy), 32'd0);
        checkOutput("stray_ack_valid", 32'(o_rd_valid), 32'd0);
        tick();
        checkOutput("stray_ack_done2", 32'(o_done), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
